// File: rtl/fft_frame_sequencer_if.sv
// Streaming bundle for fft_frame_sequencer: sample input and bin output handshakes.
// slave is the sequencer's view; master is the source/sink environment.
interface fft_frame_sequencer_if #(
    parameter int POINT_FFT_POW2 = 4,
    parameter int FRAC_BITS      = 15
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [1:0][FRAC_BITS:0]   in_data_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [1:0][FRAC_BITS:0]   out_data_o;
    logic [POINT_FFT_POW2-1:0] out_index_o;
    logic                      out_last_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_index_o, out_last_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_index_o, out_last_o
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer around a combinational FFT core: fills a frame buffer, settles, captures, streams bins.
// Optional macro FFT_SCALE_EN: captured bins are arithmetic-shifted right by POINT_FFT_POW2 (1/N scaling).
module fft_frame_sequencer #(
    parameter int POINT_FFT_POW2 = 4,
    parameter int FRAC_BITS      = 15,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    fft_frame_sequencer_if.slave                              bus,
    output logic [(1<<POINT_FFT_POW2)-1:0][1:0][FRAC_BITS:0] fft_in_o,
    input  logic [(1<<POINT_FFT_POW2)-1:0][1:0][FRAC_BITS:0] fft_out_i,
    output logic                                              busy_o,
    output logic [7:0]                                        frame_count_o
);
    localparam int POINT_FFT = 1 << POINT_FFT_POW2;
    localparam int CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]          SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [POINT_FFT_POW2-1:0] LAST_IDX    = POINT_FFT_POW2'(POINT_FFT - 1);

    typedef logic [1:0][FRAC_BITS:0] cplx_t;
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, UNLOAD} state_t;

    localparam state_t START = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;

    state_t                    state, next_state;
    cplx_t [POINT_FFT-1:0]     ibuf, obuf, capture_val;
    logic [POINT_FFT_POW2-1:0] wr_idx, rd_idx;
    logic                      in_full;
    logic [CNT_W-1:0]          settle_cnt;
    logic                      accept, fill_done, out_fire, last_fire;

`ifdef FFT_SCALE_EN
    function automatic cplx_t scale_bin(input cplx_t b);
        cplx_t r;
        for (int c = 0; c < 2; c++) begin
            r[c] = $signed(b[c]) >>> POINT_FFT_POW2;
        end
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < POINT_FFT; k++) begin
            capture_val[k] = scale_bin(fft_out_i[k]);
        end
    end
`else
    assign capture_val = fft_out_i;
`endif

    assign accept    = bus.in_valid_i && !in_full;
    assign fill_done = accept && (wr_idx == LAST_IDX);
    assign out_fire  = (state == UNLOAD) && bus.out_ready_i;
    assign last_fire = out_fire && (rd_idx == LAST_IDX);

    // IDLE also reacts to a fill completing this cycle, so the frame starts
    // settling in the same cycle in_full becomes visible.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_full || fill_done) next_state = START;
            SETTLE:  if (settle_cnt <= CNT_W'(1)) next_state = CAPTURE;
            CAPTURE: next_state = UNLOAD;
            UNLOAD:  if (last_fire) next_state = in_full ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            wr_idx        <= '0;
            rd_idx        <= '0;
            in_full       <= 1'b0;
            settle_cnt    <= '0;
            frame_count_o <= '0;
            ibuf          <= '0;
            obuf          <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                ibuf[wr_idx] <= bus.in_data_i;
                wr_idx       <= wr_idx + 1'b1;
            end
            if (fill_done) in_full <= 1'b1;
            if (next_state == SETTLE && state != SETTLE) settle_cnt <= SETTLE_LOAD;
            else if (state == SETTLE)                    settle_cnt <= settle_cnt - 1'b1;
            // in_full is always set during CAPTURE, so no fill can collide with this clear
            if (state == CAPTURE) begin
                obuf    <= capture_val;
                in_full <= 1'b0;
                rd_idx  <= '0;
            end
            if (out_fire)  rd_idx        <= rd_idx + 1'b1;
            if (last_fire) frame_count_o <= frame_count_o + 1'b1;
        end
    end

    assign bus.in_ready_o  = !in_full;
    assign bus.out_valid_o = (state == UNLOAD);
    assign bus.out_data_o  = obuf[rd_idx];
    assign bus.out_index_o = rd_idx;
    assign bus.out_last_o  = (state == UNLOAD) && (rd_idx == LAST_IDX);
    assign fft_in_o        = ibuf;
    assign busy_o          = (state != IDLE) || in_full;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with an identity (or constant, under FFT_SCALE_EN) FFT stub.
module tb_fft_frame_sequencer;
    localparam int POW2 = 4;
    localparam int N    = 16;
    localparam int FB   = 15;

    typedef logic [1:0][FB:0] cplx_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_frame_sequencer_if #(.POINT_FFT_POW2(POW2), .FRAC_BITS(FB)) bus ();
    fft_frame_sequencer_if #(.POINT_FFT_POW2(POW2), .FRAC_BITS(FB)) bus0 ();

    cplx_t [N-1:0] fft_in, fft_out, fft_in0, fft_out0;
    logic          busy, busy0;
    logic [7:0]    fc, fc0;

`ifdef FFT_SCALE_EN
    assign fft_out  = {N{32'h8000_4000}};
    assign fft_out0 = {N{32'h8000_4000}};
`else
    assign fft_out  = fft_in;
    assign fft_out0 = fft_in0;
`endif

    fft_frame_sequencer #(.POINT_FFT_POW2(POW2), .FRAC_BITS(FB), .SETTLE_CYCLES(2)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .fft_in_o(fft_in), .fft_out_i(fft_out),
        .busy_o(busy), .frame_count_o(fc)
    );

    fft_frame_sequencer #(.POINT_FFT_POW2(POW2), .FRAC_BITS(FB), .SETTLE_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0), .fft_in_o(fft_in0), .fft_out_i(fft_out0),
        .busy_o(busy0), .frame_count_o(fc0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // pattern 0: Re = n*0x0100, Im = -n; pattern 1: Re = 0x1000 + 17n, Im = -512n
    function automatic cplx_t sample(input int pat, input int n);
        logic [15:0] re, im;
        if (pat == 0) begin
            re = 16'(n * 256);
            im = 16'(-n);
        end else begin
            re = 16'(4096 + n * 17);
            im = 16'(-(n * 512));
        end
        return {im, re};
    endfunction

    function automatic cplx_t exp_bin(input int pat, input int n);
`ifdef FFT_SCALE_EN
        return {16'hF800, 16'h0400};
`else
        return sample(pat, n);
`endif
    endfunction

    task automatic push_frame(input int pat, output int t_last);
        int n = 0;
        t_last = -1;
        for (int g = 0; g < 200 && n < N; g++) begin
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = sample(pat, n);
            if (bus.in_ready_o) begin
                if (n == N - 1) t_last = cyc;
                n++;
            end
        end
        check("push_count", n, N);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        check("in_ready_low_when_full", 32'(bus.in_ready_o), 0);
        check("busy_when_full", 32'(busy), 1);
    endtask

    task automatic pull_frame(input int pat, input int nbins, input bit toggle, input int stall,
                              output int t_first, output int t_hs);
        int   k = 0;
        int   st = stall;
        logic rdy = 1'b0;
        t_first = -1;
        t_hs    = -1;
        for (int g = 0; g < 400 && k < nbins; g++) begin
            @(negedge clk);
            if (bus.out_valid_o && t_first < 0) t_first = cyc;
            if (bus.out_valid_o && st > 0) begin
                st--;
                rdy = 1'b0;
            end else begin
                rdy = toggle ? !rdy : 1'b1;
            end
            bus.out_ready_i = rdy;
            if (bus.out_valid_o) begin
                check("bin_index", 32'(bus.out_index_o), k);
                check("bin_data", bus.out_data_o, exp_bin(pat, k));
                check("bin_last", 32'(bus.out_last_o), 32'(k == N - 1));
                if (rdy) begin
                    t_hs = cyc;
                    k++;
                end
            end
        end
        check("pull_count", k, nbins);
    endtask

    initial begin
        int t1, t2, tf1, tf2, h1, h2, n0, ts0;
        rst = 1'b1;
        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = '0;
        bus.out_ready_i  = 1'b0;
        bus0.in_valid_i  = 1'b0;
        bus0.in_data_i   = '0;
        bus0.out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid_o), 0);
        check("rst_in_ready", 32'(bus.in_ready_o), 1);
        check("rst_frame_count", 32'(fc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_index", 32'(bus.out_index_o), 0);
        check("rst_out_last", 32'(bus.out_last_o), 0);
        check("rst_fft_in", fft_in[0], 0);

        // single frame, always ready
        fork
            push_frame(0, t1);
            pull_frame(0, N, 1'b0, 0, tf1, h1);
        join
        check("latency_settle2", tf1, t1 + 4);
        check("frame_buf_5", fft_in[5], sample(0, 5));
        @(negedge clk);
        check("frame_count_1", 32'(fc), 1);
        check("idle_not_busy", 32'(busy), 0);

        // ready toggling every cycle
        fork
            push_frame(1, t1);
            pull_frame(1, N, 1'b1, 0, tf1, h1);
        join
        @(negedge clk);
        check("frame_count_2", 32'(fc), 2);

        // back-to-back, fill of frame 2 finishes in the cycle of frame 1's last handshake
        fork
            begin push_frame(0, t1); push_frame(1, t2); end
            begin pull_frame(0, N, 1'b0, 0, tf1, h1); pull_frame(1, N, 1'b0, 0, tf2, h2); end
        join
        check("collide_same_cycle", t2, h1);
        check("collide_idle_gap", tf2, h1 + 5);
        @(negedge clk);
        check("frame_count_4", 32'(fc), 4);

        // back-to-back, frame 2 full before frame 1's last handshake
        fork
            begin push_frame(1, t1); push_frame(0, t2); end
            begin pull_frame(1, N, 1'b0, 2, tf1, h1); pull_frame(0, N, 1'b0, 0, tf2, h2); end
        join
        check("b2b_fill_early", 32'(t2 < h1), 1);
        check("b2b_no_idle", tf2, h1 + 4);
        @(negedge clk);
        check("frame_count_6", 32'(fc), 6);

        // reset in the middle of unloading
        fork
            push_frame(0, t1);
            pull_frame(0, 7, 1'b0, 0, tf1, h1);
        join
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid_o), 0);
        check("midrst_in_ready", 32'(bus.in_ready_o), 1);
        check("midrst_frame_count", 32'(fc), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_fft_in", fft_in[2], 0);
        fork
            push_frame(1, t1);
            pull_frame(1, N, 1'b0, 0, tf1, h1);
        join
        check("postrst_latency", tf1, t1 + 4);
        @(negedge clk);
        check("postrst_frame_count", 32'(fc), 1);

        // zero settle cycles
        n0 = 0;
        ts0 = -1;
        for (int g = 0; g < 100 && n0 < N; g++) begin
            @(negedge clk);
            bus0.in_valid_i = 1'b1;
            bus0.in_data_i  = sample(0, n0);
            if (bus0.in_ready_o) begin
                if (n0 == N - 1) ts0 = cyc;
                n0++;
            end
        end
        @(negedge clk);
        bus0.in_valid_i  = 1'b0;
        bus0.out_ready_i = 1'b1;
        tf2 = -1;
        for (int g = 0; g < 50; g++) begin
            if (bus0.out_valid_o) begin
                tf2 = cyc;
                break;
            end
            @(negedge clk);
        end
        check("latency_settle0", tf2, ts0 + 2);
        check("settle0_bin0", bus0.out_data_o, exp_bin(0, 0));
        repeat (N + 1) @(negedge clk);
        check("settle0_frame_count", 32'(fc0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Sequencer wrapped around the combinational top_fft core (POINT_FFT-point, Q1.FRAC_BITS complex arrays).
- Collects a streamed frame of complex samples into a frame buffer that drives the core's data_i.
- Waits a programmable settle time, then captures the core's data_o into an output buffer and streams the bins out with a valid/ready handshake.
- Input and output buffers are separate, so the next frame can be loaded while the current one unloads.

Parameters:
POINT_FFT_POW2, 4, log2 of FFT size; POINT_FFT = 1 << POINT_FFT_POW2
FRAC_BITS, 15, fraction bits; every sample/bin is [1:0][FRAC_BITS:0] signed, [0]=Re, [1]=Im
SETTLE_CYCLES, 2, cycles the frame buffer is held stable before capture; 0 is legal

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
in_valid_i  in  1  input sample valid
in_ready_o  out  1  sequencer accepts a sample this cycle
in_data_i  in  [1:0][FRAC_BITS:0]  input sample
out_valid_o  out  1  output bin valid
out_ready_i  in  1  downstream accepts bin
out_data_o  out  [1:0][FRAC_BITS:0]  output bin
out_index_o  out  POINT_FFT_POW2  bin index k of out_data_o
out_last_o  out  1  high with bin POINT_FFT-1
fft_in_o  out  [1:0][FRAC_BITS:0] x POINT_FFT  frame buffer, drives top_fft data_i
fft_out_i  in  [1:0][FRAC_BITS:0] x POINT_FFT  from top_fft data_o
busy_o  out  1  state != IDLE or in_full
frame_count_o  out  8  completed frames, wraps 255->0

Behaviour:
- Clock and reset: one clock (clk_i). rst_i is synchronous and active-high.
- Reset values: all buffers 0, wr_idx 0, in_full 0, state IDLE, out_valid_o 0, out_index_o 0, out_last_o 0, frame_count_o 0, busy_o 0.
- Fill side:
  - in_ready_o = !in_full (combinational from registers).
  - On in_valid_i && in_ready_o: buf[wr_idx] <= in_data_i; wr_idx++.
  - On accepting index POINT_FFT-1: wr_idx wraps to 0 and in_full <= 1.
  - in_valid_i is ignored while in_ready_o is low.
- fft_in_o = buf, combinationally. It is stable whenever in_full=1.
- FSM states: IDLE, SETTLE, CAPTURE, UNLOAD.
  - IDLE: if in_full, load settle counter with SETTLE_CYCLES and go to SETTLE, or go straight to CAPTURE when SETTLE_CYCLES=0.
  - SETTLE: decrement the counter; when it reaches 0 go to CAPTURE. Exactly SETTLE_CYCLES cycles are spent in SETTLE.
  - CAPTURE (one cycle): obuf <= fft_out_i, in_full <= 0, rd_idx <= 0, go to UNLOAD.
  - UNLOAD:
    - out_valid_o=1, out_data_o=obuf[rd_idx], out_index_o=rd_idx, out_last_o=(rd_idx==POINT_FFT-1).
    - On out_valid_o && out_ready_i: rd_idx++.
    - On the last handshake: frame_count_o++; go to SETTLE (reload counter) if in_full, else IDLE.
- Output holding: out_data_o/out_index_o hold while out_valid_o && !out_ready_i. out_valid_o is 0 outside UNLOAD.
- Latency: last input accept at cycle T puts the first out_valid_o at T+SETTLE_CYCLES+2 (in_full visible T+1, SETTLE, CAPTURE, UNLOAD).
- Back-to-back frames: the first sample of the next frame can be accepted in the cycle after CAPTURE. A new frame filled during UNLOAD starts SETTLE immediately after the last handshake, with no IDLE cycle.
- Simultaneous events:
  - CAPTURE clearing in_full takes priority. No sample is accepted in CAPTURE because in_ready_o is low.
  - Completing a fill in the same cycle as the last unload handshake: in_full is already seen as 0 in that cycle, so the FSM goes to IDLE, then SETTLE the next cycle.
- Reset mid-operation: any partial frame and unsent bins are discarded, all state returns to reset values, and no out_valid_o is asserted in the cycle after reset.
- Arithmetic: no arithmetic on data; bins pass unchanged (see Optional Feature).

Optional Feature:
FFT_SCALE_EN
- Defined: each captured bin component is arithmetic-shifted right by POINT_FFT_POW2 (floor, sign-extended) at CAPTURE, i.e. scaled by 1/N.
- Undefined: bins are captured unmodified.

Test Plan:
Bench replaces top_fft with a stub: an identity stub (fft_out_i = fft_in_o) unless stated; with identity, bins reproduce inputs.
- Reset, then 16 samples Re=n*0x0100, Im=-n, out_ready_i=1 -> 16 bins, out_index_o 0..15, values match, out_last_o only at k=15, frame_count_o=1.
- SETTLE_CYCLES=2: last accept at cycle T -> out_valid_o first high at T+4. With SETTLE_CYCLES=0 -> T+2.
- out_ready_i toggled 1/0 every cycle -> each bin is held until accepted, no duplicates or drops, 16 handshakes total.
- Second frame streamed during UNLOAD of the first, out_ready_i=1 -> in_ready_o low after 16 accepts, frame 2 enters SETTLE right after frame 1's last handshake, frame_count_o=2.
- Assert rst_i after 7 bins -> out_valid_o=0, in_ready_o=1, frame_count_o=0 next cycle; a fresh frame unloads correctly.
- FFT_SCALE_EN with a constant stub returning Re=0x4000, Im=0x8000 -> out Re=0x0400, Im=0xF800 for all bins.
